led_fader: RTL and testbench
============================

LED_FADER -- requirements
Module: led_fader

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 25_000_000, giving the input clock frequency in Hz (informative only; used to derive the FADE_DIV default).
REQ-002 The block SHALL have parameter FADE_DIV, default CLK_FREQ/1024, giving the clocks per fade tick; legal range is 1 or more.
REQ-003 The block SHALL have parameter RISE_STEP, default 8, giving the brightness increment per tick; legal range is 1..255.
REQ-004 The block SHALL have parameter FALL_STEP, default 4, giving the brightness decrement per tick; legal range is 1..255.
REQ-005 Port clk, input, 1 bit, SHALL be the clock; all logic is on the rising edge.
REQ-006 Port rst_n, input, 1 bit, SHALL be the reset: synchronous, active-low; clock clk.
REQ-007 Port pattern_in, input, 8 bits, SHALL carry the target on/off LED pattern from the upstream shifter; it may change on any cycle.
REQ-008 Port enable, input, 1 bit, SHALL be high to run; low blanks the outputs and freezes the fade.
REQ-009 Port leds_out, output, 8 bits, SHALL carry the registered PWM drive, one bit per LED.
REQ-010 Port busy, output, 1 bit, SHALL be high while any LED brightness differs from its target.

Function
REQ-011 pattern_in SHALL be registered into pattern_q with 1 cycle of latency; target[i] = pattern_q[i] ? 255 : 0.
REQ-012 The tick counter SHALL count 0..FADE_DIV-1 and wrap; a tick pulses for 1 cycle when the count is FADE_DIV-1 and enable=1. With FADE_DIV=1, every enabled cycle is a tick.
REQ-013 The block SHALL hold eight 8-bit brightness registers bright[i]; they change only on a tick.
REQ-014 On a tick, if bright[i]<target[i], bright[i] SHALL become min(255, bright[i]+RISE_STEP), computed at 9-bit width with no wrap.
REQ-015 On a tick, if bright[i]>target[i], bright[i] SHALL become max(0, bright[i]-FALL_STEP), with no underflow.
REQ-016 On a tick, if bright[i]==target[i], bright[i] SHALL hold.
REQ-017 A pattern change mid-ramp SHALL reverse direction on the next tick from the current value, with no restart.
REQ-018 The PWM counter SHALL be free-running 0..254 (period 255 cycles) and SHALL run regardless of enable.
REQ-019 leds_out[i] SHALL be registered as enable & (pwm_cnt < duty[i]), where duty[i] = bright[i] unless modified by REQ-025.
REQ-020 Duty 0 SHALL give leds_out[i] constantly 0; duty 255 SHALL give it constantly 1.
REQ-021 With enable=0, leds_out SHALL be 0 from the next cycle; bright[] and the tick counter SHALL freeze; pattern_q SHALL keep sampling.
REQ-022 busy SHALL be combinational from the registers: OR over i of (bright[i] != target[i]).

Reset
REQ-023 While rst_n=0 at a clock edge, the block SHALL set pattern_q=0, bright[]=0, tick counter=0, pwm_cnt=0 and leds_out=0x00; busy is consequently 0.
REQ-024 Reset asserted mid-ramp SHALL take priority over all other updates; after release, fading SHALL restart from 0.

Configuration
REQ-025 With macro LED_FADER_GAMMA_EN defined, duty[i] SHALL be (bright[i]*bright[i] + 255) >> 8, computed at 16-bit width, so that 0 maps to 0, 255 maps to 255 and the curve is quadratic.
REQ-026 Without LED_FADER_GAMMA_EN, duty[i] SHALL equal bright[i], and no multiplier logic SHALL be present.

Verification
(All scenarios use FADE_DIV=4, RISE_STEP=64, FALL_STEP=32, enable=1 and the gamma macro undefined unless stated.)
REQ-027 Rise: reset, then pattern_in=0x01 -> bright[0] takes 64, 128, 192, 255 on successive ticks; busy drops after the 4th tick; leds_out[0] is high for exactly 64 of 255 PWM cycles at the first step.
REQ-028 Fall: from bright[0]=255, set pattern_in=0x00 -> bright[0] takes 223, 191, ..., 31, then 0 after 8 ticks, with no underflow; leds_out[0] is constantly 0 afterwards.
REQ-029 Reversal: at bright[0]=128 on the rise, clear bit 0 -> the next tick gives 96; set it again -> the following tick gives 160.
REQ-030 Enable: enable=0 mid-ramp at bright=128 -> leds_out=0x00 on the next cycle, bright holds 128 for 20 cycles; re-enable -> ramping resumes from 128.
REQ-031 Reset mid-ramp: rst_n=0 for 1 cycle at bright[3]=192 -> all outputs are 0 the next cycle; ramping restarts from 0.
REQ-032 Gamma (LED_FADER_GAMMA_EN defined): bright=128 -> 64 high cycles per 255-cycle period; bright=255 -> leds_out constantly 1.

Source files
------------

// File: rtl/led_fader.sv
// Eight-channel LED fader: ramps each LED's brightness toward an on/off target and drives PWM outputs.
// Define LED_FADER_GAMMA_EN to apply a quadratic gamma curve to the PWM duty.
module led_fader #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int FADE_DIV  = CLK_FREQ / 1024,
  parameter int RISE_STEP = 8,
  parameter int FALL_STEP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pattern_in,
  input  logic       enable,
  output logic [7:0] leds_out,
  output logic       busy
);
  localparam int               CNT_W   = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FADE_DIV - 1);
  localparam logic [8:0]       RISE    = 9'(RISE_STEP);
  localparam logic [8:0]       FALL    = 9'(FALL_STEP);

  logic [7:0]       pattern_q, pattern_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]       pwm_cnt_q, pwm_cnt_d;
  logic [7:0]       bright_q [8];
  logic [7:0]       bright_d [8];
  logic [7:0]       leds_q, leds_d;
  logic [7:0]       duty [8];
  logic [7:0]       diff;
  logic             tick;

  // Saturating ramp steps, widened to 9 bits so neither direction can wrap.
  function automatic logic [7:0] step_up(input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, b} + RISE;
    return (sum > 9'd255) ? 8'd255 : sum[7:0];
  endfunction

  function automatic logic [7:0] step_down(input logic [7:0] b);
    logic [8:0] dif;
    dif = {1'b0, b} - FALL;
    return ({1'b0, b} <= FALL) ? 8'd0 : dif[7:0];
  endfunction

`ifdef LED_FADER_GAMMA_EN
  function automatic logic [7:0] gamma(input logic [7:0] b);
    return 8'((16'(b) * 16'(b) + 16'd255) >> 8);
  endfunction
`endif

  always_comb begin
    pattern_d  = pattern_in;
    tick       = enable && (tick_cnt_q == CNT_MAX);
    tick_cnt_d = tick_cnt_q;
    if (enable) tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
    pwm_cnt_d  = (pwm_cnt_q == 8'd254) ? 8'd0 : pwm_cnt_q + 8'd1;
    for (int i = 0; i < 8; i++) begin
      bright_d[i] = bright_q[i];
      if (tick) begin
        if (bright_q[i] < {8{pattern_q[i]}})      bright_d[i] = step_up(bright_q[i]);
        else if (bright_q[i] > {8{pattern_q[i]}}) bright_d[i] = step_down(bright_q[i]);
      end
      diff[i] = (bright_q[i] != {8{pattern_q[i]}});
`ifdef LED_FADER_GAMMA_EN
      duty[i] = gamma(bright_q[i]);
`else
      duty[i] = bright_q[i];
`endif
      // Counter tops out at 254, so duty 255 keeps the LED permanently on.
      leds_d[i] = enable && (pwm_cnt_q < duty[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pattern_q  <= '0;
      tick_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      leds_q     <= '0;
      for (int i = 0; i < 8; i++) bright_q[i] <= '0;
    end else begin
      pattern_q  <= pattern_d;
      tick_cnt_q <= tick_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      leds_q     <= leds_d;
      for (int i = 0; i < 8; i++) bright_q[i] <= bright_d[i];
    end
  end

  assign leds_out = leds_q;
  assign busy     = |diff;

endmodule

// File: tb/tb_led_fader.sv
// Scoreboard bench for led_fader: a fast-fade instance checks brightness sequences and control,
// a slow-fade instance checks PWM high-cycle counts per brightness step.
module tb_led_fader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, enable, busy;
  logic [7:0] pattern_in, leds_out;
  logic       rst_n_p, enable_p, busy_p;
  logic [7:0] pattern_p, leds_p;

  led_fader #(.CLK_FREQ(25_000_000), .FADE_DIV(4), .RISE_STEP(64), .FALL_STEP(32)) dut (
    .clk(clk), .rst_n(rst_n), .pattern_in(pattern_in), .enable(enable),
    .leds_out(leds_out), .busy(busy));

  led_fader #(.CLK_FREQ(25_000_000), .FADE_DIV(600), .RISE_STEP(64), .FALL_STEP(32)) dut_p (
    .clk(clk), .rst_n(rst_n_p), .pattern_in(pattern_p), .enable(enable_p),
    .leds_out(leds_p), .busy(busy_p));

`ifdef LED_FADER_GAMMA_EN
  localparam int D64 = 16, D128 = 64;
`else
  localparam int D64 = 64, D128 = 128;
`endif

  typedef struct { int lane; int val; } bexp_t;
  typedef struct { int kind; int val; } pexp_t;

  bexp_t      bq[$];
  pexp_t      pq[$];
  bexp_t      be_m;
  pexp_t      pe_m;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         hi_cnt = 0;
  bit         mon_en = 1'b0;
  logic [7:0] last [8];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_b(input int l, input int v);
    bq.push_back('{lane: l, val: v});
  endtask

  // kind: 0 leds_out, 1 busy, 2 slow-instance PWM high count, 3 busy_p, 4 leds_p
  task automatic expect_port(input int k, input int v);
    pq.push_back('{kind: k, val: v});
  endtask

  task automatic wait_bright(input int lane, input int val, input int budget);
    int k = 0;
    while (k < budget && int'(dut.bright_q[lane]) != val) begin
      @(posedge clk);
      #1;
      k++;
    end
    check($sformatf("reach_bright%0d_%0d", lane, val), int'(dut.bright_q[lane]), val);
  endtask

  task automatic measure_pwm(input int exp);
    int hi = 0;
    repeat (255) begin
      if (leds_p[0]) hi++;
      step(1);
    end
    hi_cnt = hi;
    expect_port(2, exp);
  endtask

  // Monitor: every brightness change pops the next expected (lane, value); port checks drain each cycle.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (mon_en && dut.bright_q[i] !== last[i]) begin
        if (bq.size() == 0) begin
          check($sformatf("unexpected_bright%0d_change", i), int'(dut.bright_q[i]), int'(last[i]));
        end else begin
          be_m = bq.pop_front();
          check("bright lane*1000+value", i * 1000 + int'(dut.bright_q[i]), be_m.lane * 1000 + be_m.val);
        end
      end
      last[i] = dut.bright_q[i];
    end
    while (pq.size() > 0) begin
      pe_m = pq.pop_front();
      case (pe_m.kind)
        0:       check("leds_out", int'(leds_out), pe_m.val);
        1:       check("busy", int'(busy), pe_m.val);
        2:       check("pwm_high_cycles", hi_cnt, pe_m.val);
        3:       check("busy_p", int'(busy_p), pe_m.val);
        default: check("leds_p", int'(leds_p), pe_m.val);
      endcase
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b1; pattern_in = 8'h00;
    rst_n_p = 1'b0; enable_p = 1'b1; pattern_p = 8'h00;
    step(3);
    mon_en = 1'b1;
    expect_port(0, 0);
    expect_port(1, 0);
    step(1);

    // Rise from reset
    rst_n = 1'b1; pattern_in = 8'h01;
    push_b(0, 64); push_b(0, 128); push_b(0, 192); push_b(0, 255);
    step(2);
    expect_port(1, 1);
    wait_bright(0, 255, 40);
    step(1);
    expect_port(1, 0);

    // Fall to zero without underflow
    pattern_in = 8'h00;
    for (int v = 223; v >= 31; v -= 32) push_b(0, v);
    push_b(0, 0);
    step(2);
    expect_port(1, 1);
    wait_bright(0, 0, 60);
    step(1);
    for (int i = 0; i < 5; i++) begin
      expect_port(0, 0);
      expect_port(1, 0);
      step(1);
    end

    // Direction reversal mid-ramp
    pattern_in = 8'h01;
    push_b(0, 64); push_b(0, 128);
    wait_bright(0, 128, 20);
    pattern_in = 8'h00;
    push_b(0, 96);
    wait_bright(0, 96, 20);
    pattern_in = 8'h01;
    push_b(0, 160); push_b(0, 224); push_b(0, 255);
    wait_bright(0, 255, 30);

    // Reset mid-ramp on lane 3
    pattern_in = 8'h09;
    push_b(3, 64); push_b(3, 128); push_b(3, 192);
    wait_bright(3, 192, 30);
    rst_n = 1'b0; pattern_in = 8'h01;
    push_b(0, 0); push_b(3, 0);
    step(1);
    rst_n = 1'b1;
    expect_port(0, 0);
    expect_port(1, 0);
    push_b(0, 64); push_b(0, 128);

    // Enable freeze at 128, then resume
    wait_bright(0, 128, 20);
    enable = 1'b0;
    step(1);
    expect_port(1, 1);
    for (int i = 0; i < 20; i++) begin
      expect_port(0, 0);
      step(1);
    end
    enable = 1'b1;
    push_b(0, 192); push_b(0, 255);
    wait_bright(0, 255, 30);
    step(1);
    expect_port(1, 0);
    step(2);
    check("unconsumed_bright_expectations", bq.size(), 0);

    // PWM duty on the slow instance
    rst_n_p = 1'b1; pattern_p = 8'h01;
    step(700);
    measure_pwm(D64);
    step(345);
    measure_pwm(D128);
    step(945);
    measure_pwm(255);
    pattern_p = 8'h00;
    step(4745);
    measure_pwm(0);
    expect_port(3, 0);
    expect_port(4, 0);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
